// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one TMDS receive channel.
// Takes unaligned 10-bit deserializer words (bit 0 is first on the wire) and
// finds the word boundary by hunting for runs of control tokens. Once aligned,
// it decodes the 8-bit pixel data, the 2-bit control value and video-data-enable.
// All outputs are registered. From the edge that samples the first bit of a
// word to that word's decoded outputs is 3 clocks, at every bit offset.
// Optional feature: define TMDS_DEC_STATS_EN to add lock_loss_cnt_o, a
// saturating count of lock losses that only reset clears.

module tmds_channel_decoder #(
    parameter int TOKEN_RUN    = 8,
    parameter int SEARCH_WORDS = 2048,
    parameter int MAX_DATA_RUN = 2047
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [9:0] tmds_raw_i,
    output logic [7:0] data_o,
    output logic [1:0] ctl_o,
    output logic       vde_o,
    output logic       locked_o,
    output logic [3:0] bit_offset_o
`ifdef TMDS_DEC_STATS_EN
    ,
    output logic [7:0] lock_loss_cnt_o
`endif
);

    localparam int RUN_W  = (TOKEN_RUN    > 1) ? $clog2(TOKEN_RUN)    : 1;
    localparam int WORD_W = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
    localparam int DATA_W = (MAX_DATA_RUN > 1) ? $clog2(MAX_DATA_RUN) : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(SEARCH_WORDS - 1);
    localparam logic [DATA_W-1:0] DATA_LAST = DATA_W'(MAX_DATA_RUN - 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e              state_q;
    logic [9:0]          raw_q;
    logic [9:0]          raw_qq;
    logic [3:0]          bit_offset_q;
    logic [RUN_W-1:0]    run_cnt_q;
    logic [WORD_W-1:0]   word_cnt_q;
    logic [DATA_W-1:0]   data_cnt_q;
    logic [7:0]          data_q;
    logic [1:0]          ctl_q;
    logic                vde_q;
    logic                locked_q;

    logic [18:0]         win;
    logic [9:0]          cand;
    logic                is_tok;
    logic [1:0]          tok_val;
    logic [7:0]          q_unmask;
    logic [7:0]          dec_data;
    logic [3:0]          bit_offset_inc;
    logic                lock_lost;

    // Two-word history: the older word sits in the low bits, so any 10-bit
    // slice starting at bit_offset is a contiguous run of wire bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raw_q  <= '0;
            raw_qq <= '0;
        end else begin
            raw_q  <= tmds_raw_i;
            raw_qq <= raw_q;
        end
    end

    assign win = {raw_q[8:0], raw_qq};

    // Candidate word at the current bit offset.
    always_comb begin
        cand = win[9:0];
        case (bit_offset_q)
            4'd0:    cand = win[9:0];
            4'd1:    cand = win[10:1];
            4'd2:    cand = win[11:2];
            4'd3:    cand = win[12:3];
            4'd4:    cand = win[13:4];
            4'd5:    cand = win[14:5];
            4'd6:    cand = win[15:6];
            4'd7:    cand = win[16:7];
            4'd8:    cand = win[17:8];
            4'd9:    cand = win[18:9];
            default: cand = win[9:0];
        endcase
    end

    // Control token recognition; tokens have 7 transitions, data at most 5.
    always_comb begin
        is_tok  = 1'b0;
        tok_val = 2'b00;
        case (cand)
            10'b1101010100: begin is_tok = 1'b1; tok_val = 2'b00; end
            10'b0010101011: begin is_tok = 1'b1; tok_val = 2'b01; end
            10'b0101010100: begin is_tok = 1'b1; tok_val = 2'b10; end
            10'b1010101011: begin is_tok = 1'b1; tok_val = 2'b11; end
            default:        begin is_tok = 1'b0; tok_val = 2'b00; end
        endcase
    end

    // Undo the DC-balance inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q_unmask = cand[9] ? ~cand[7:0] : cand[7:0];
        dec_data = '0;
        dec_data[0] = q_unmask[0];
        for (int i = 1; i < 8; i++) begin
            dec_data[i] = cand[8] ? (q_unmask[i] ^ q_unmask[i-1])
                                  : ~(q_unmask[i] ^ q_unmask[i-1]);
        end
    end

    assign bit_offset_inc = (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;
    assign lock_lost      = (state_q == ST_LOCKED) && !is_tok && (data_cnt_q == DATA_LAST);

    // Alignment FSM with its counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_SEARCH;
            bit_offset_q <= '0;
            run_cnt_q    <= '0;
            word_cnt_q   <= '0;
            data_cnt_q   <= '0;
            data_q       <= '0;
            ctl_q        <= '0;
            vde_q        <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    data_q     <= '0;
                    vde_q      <= 1'b0;
                    ctl_q      <= '0;
                    word_cnt_q <= word_cnt_q + WORD_W'(1);
                    run_cnt_q  <= is_tok ? run_cnt_q + RUN_W'(1) : '0;
                    // Lock takes priority over stepping the offset.
                    if (is_tok && (run_cnt_q == RUN_LAST)) begin
                        state_q    <= ST_LOCKED;
                        locked_q   <= 1'b1;
                        run_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        data_cnt_q <= '0;
                    end else if (word_cnt_q == WORD_LAST) begin
                        bit_offset_q <= bit_offset_inc;
                        run_cnt_q    <= '0;
                        word_cnt_q   <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_tok) begin
                        vde_q      <= 1'b0;
                        ctl_q      <= tok_val;
                        data_cnt_q <= '0;
                    end else if (lock_lost) begin
                        // Too long without a token: this offset is wrong.
                        state_q      <= ST_SEARCH;
                        locked_q     <= 1'b0;
                        data_q       <= '0;
                        vde_q        <= 1'b0;
                        ctl_q        <= '0;
                        bit_offset_q <= bit_offset_inc;
                        data_cnt_q   <= '0;
                    end else begin
                        vde_q      <= 1'b1;
                        data_q     <= dec_data;
                        data_cnt_q <= data_cnt_q + DATA_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef TMDS_DEC_STATS_EN
    logic [7:0] lock_loss_cnt_q;

    // Saturating count of LOCKED->SEARCH transitions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_loss_cnt_q <= '0;
        end else if (lock_lost && (lock_loss_cnt_q != 8'hFF)) begin
            lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt_o = lock_loss_cnt_q;
`endif

    assign data_o       = data_q;
    assign ctl_o        = ctl_q;
    assign vde_o        = vde_q;
    assign locked_o     = locked_q;
    assign bit_offset_o = bit_offset_q;

endmodule
